// File: rtl/l1_sram_1r1w_fwd_if.sv
// Port bundle for the 1W/1R L1 SRAM model.
// Master drives the write/read requests, slave returns read data.
interface l1_sram_1r1w_fwd_if #(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH;

    logic                  csb0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  init_busy;

    modport master (
        output csb0, wmask0, addr0, din0, csb1, addr1,
        input  dout1, dout1_valid, init_busy
    );

    modport slave (
        input  csb0, wmask0, addr0, din0, csb1, addr1,
        output dout1, dout1_valid, init_busy
    );
endinterface

// File: rtl/l1_sram_1r1w_fwd.sv
// 1W/1R byte-masked SRAM with same-cycle write-to-read forwarding,
// optional output register and post-reset zero-fill sequencer.
module l1_sram_1r1w_fwd #(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_ZERO  = 1
) (
    input logic clk,
    input logic rst_n,
    l1_sram_1r1w_fwd_if.slave bus
);
    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  init_we;
    logic                  wr_en;
    logic                  rd_en;
    logic                  busy;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ZERO != 0) ? S_INIT : S_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (init_we) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (cnt_q == '1) state_d = S_READY;
            S_READY: state_d = S_READY;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        init_we = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                busy    = 1'b1;
                init_we = 1'b1;
            end
            S_READY: begin
                wr_en = !bus.csb0;
                rd_en = !bus.csb1;
            end
        endcase
    end

    assign bus.init_busy = busy;

    // Array storage is deliberately not reset; the sequencer clears it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i])
                    mem[bus.addr0][i*BYTE_WIDTH +: BYTE_WIDTH]
                        <= bus.din0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Colliding read sees the bytes being written this edge.
    always_comb begin
        rd_word = mem[bus.addr1];
        if (wr_en && (bus.addr0 == bus.addr1)) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i])
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                        bus.din0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) s1_data <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= s1_data;
            end
        end

        assign bus.dout1       = s2_data;
        assign bus.dout1_valid = s2_valid;
    end else begin : g_no_out_reg
        assign bus.dout1       = s1_data;
        assign bus.dout1_valid = s1_valid;
    end
endmodule

// File: tb/tb_l1_sram_1r1w_fwd.sv
// Scoreboard bench: two DUTs (OUT_REG=0/1) share stimulus,
// expected read words come from a word-array model of the SRAM.
module tb_l1_sram_1r1w_fwd;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          csb0 = 1'b1;
    logic [3:0]    wmask0 = '0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] din0 = '0;
    logic          csb1 = 1'b1;
    logic [AW-1:0] addr1 = '0;

    l1_sram_1r1w_fwd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8)) if0 ();
    l1_sram_1r1w_fwd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8)) if1 ();

    assign if0.csb0 = csb0;
    assign if0.wmask0 = wmask0;
    assign if0.addr0 = addr0;
    assign if0.din0 = din0;
    assign if0.csb1 = csb1;
    assign if0.addr1 = addr1;
    assign if1.csb0 = csb0;
    assign if1.wmask0 = wmask0;
    assign if1.addr0 = addr0;
    assign if1.din0 = din0;
    assign if1.csb1 = csb1;
    assign if1.addr1 = addr1;

    l1_sram_1r1w_fwd #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
        .OUT_REG(0), .INIT_ZERO(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );

    l1_sram_1r1w_fwd #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
        .OUT_REG(1), .INIT_ZERO(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int init_left = 0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] last_e [2];
    exp_t q0[$];
    exp_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor for port k: k is also the expected extra latency.
    task automatic mon(input int k, input logic v, input logic [DW-1:0] dat);
        exp_t x;
        int   sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (v) begin
            if (sz == 0) begin
                chk1($sformatf("unexpected_valid%0d", k), v, 1'b0);
            end else begin
                x = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk32($sformatf("dout1_%0d", k), dat, x.d);
                chk_int($sformatf("latency%0d", k), cyc - x.e, k);
                last_e[k] = x.d;
            end
        end else begin
            chk32($sformatf("hold%0d", k), dat, last_e[k]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.dout1_valid, if0.dout1);
            mon(1, if1.dout1_valid, if1.dout1);
        end
    end

    // One clock edge of stimulus; entered and left at posedge+1.
    task automatic step(input logic c0, input logic [3:0] m, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d, input logic c1, input logic [AW-1:0] a1);
        exp_t x;
        chk1("init_busy0", if0.init_busy, init_left > 0);
        chk1("init_busy1", if1.init_busy, init_left > 0);
        csb0 = c0; wmask0 = m; addr0 = a0; din0 = d;
        csb1 = c1; addr1 = a1;
        if (init_left > 0) begin
            init_left--;
        end else begin
            // A colliding read sees the post-write word, so apply write first.
            if (!c0)
                for (int b = 0; b < 4; b++)
                    if (m[b]) mem_m[a0][8*b +: 8] = d[8*b +: 8];
            if (!c1) begin
                x.d = mem_m[a1];
                x.e = cyc + 1;
                q0.push_back(x);
                q1.push_back(x);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 4'h0, '0, '0, 1'b1, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        step(1'b0, m, a, d, 1'b1, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, 4'h0, '0, '0, 1'b0, a);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk32("rst_dout0", if0.dout1, '0);
        chk32("rst_dout1", if1.dout1, '0);
        chk1("rst_valid0", if0.dout1_valid, 1'b0);
        chk1("rst_valid1", if1.dout1_valid, 1'b0);
        q0.delete();
        q1.delete();
        last_e[0] = '0;
        last_e[1] = '0;
        csb0 = 1'b1;
        csb1 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Traffic during init must be ignored.
        step(1'b0, 4'hF, 4'd3, 32'hFFFF_FFFF, 1'b0, 4'd3);
        for (int i = 1; i < DEPTH; i++)
            step(1'b0, 4'(($urandom)), 4'(($urandom)), $urandom, 1'b0, 4'(($urandom)));
        for (int i = 0; i < DEPTH; i++) rd(4'(i));

        wr(4'd5, 32'hDEAD_BEEF, 4'b1111);
        rd(4'd5);
        wr(4'd5, 32'h1122_3344, 4'b0101);
        rd(4'd5);
        wr(4'd7, 32'hAAAA_AAAA, 4'b1111);
        step(1'b0, 4'b0011, 4'd7, 32'h5555_5555, 1'b0, 4'd7);
        rd(4'd7);
        wr(4'd1, 32'h1, 4'hF);
        wr(4'd2, 32'h2, 4'hF);
        wr(4'd3, 32'h3, 4'hF);
        rd(4'd1);
        rd(4'd2);
        rd(4'd3);
        idle();
        idle();
        wr(4'd6, 32'h0, 4'b0000);
        step(1'b0, 4'b0000, 4'd5, 32'hFFFF_FFFF, 1'b0, 4'd5);

        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a0, a1;
            a0 = 4'(($urandom_range(0, 7)));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'(($urandom_range(0, 7)));
            step(($urandom_range(0, 2) == 0), 4'(($urandom)), a0, $urandom,
                 ($urandom_range(0, 3) == 0), a1);
        end

        // Reset with nonzero read data held, then again mid-init.
        wr(4'd9, 32'hCAFE_F00D, 4'hF);
        rd(4'd9);
        rd(4'd9);
        idle();
        apply_reset();
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'hF, 4'(i), 32'hFFFF_FFFF, 1'b0, 4'(i));
        apply_reset();
        for (int i = 0; i < DEPTH; i++) idle();
        for (int i = 0; i < DEPTH; i++) rd(4'(i));
        for (int i = 0; i < 4; i++) idle();

        chk_int("drain0", q0.size(), 0);
        chk_int("drain1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
